// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and parameter-legality limits for the
// configurable UART controller.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int DIV_MIN        = 4;
   localparam int DIV_MAX        = 65535;
   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 8;
   localparam int FIFO_DEPTH_MIN = 2;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
   } txState_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
   } rxState_e;

   function automatic bit isPow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a separate count.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             doPush;
   logic             doPop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign doPop   = pop_i && !empty_o;
   // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
   assign doPush  = push_i && (!full_o || doPop);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (doPush) wptr_q <= wptr_q + 1'b1;
         if (doPop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_ctl_cfg.sv
// Full-duplex UART with configurable frame format, TX/RX FIFOs and
// valid/ready handshakes; reports parity, framing and overrun errors.
module uart_ctl_cfg
   import uart_pkg::*;
#(
   parameter int DIV        = 434,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_ovr,
   input  logic                 rx_ovr_clr
);

   if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_badDiv
      $error("uart_ctl_cfg: DIV out of range");
   end
   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_badDataBits
      $error("uart_ctl_cfg: DATA_BITS out of range");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_badParity
      $error("uart_ctl_cfg: illegal PARITY");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStop
      $error("uart_ctl_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < FIFO_DEPTH_MIN || !isPow2(FIFO_DEPTH)) begin : g_badDepth
      $error("uart_ctl_cfg: FIFO_DEPTH must be a power of two >= 2");
   end

   localparam logic [15:0] BIT_RELOAD  = 16'(DIV - 1);
   localparam logic [15:0] HALF_RELOAD = 16'(DIV / 2 - 1);
   localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);
   localparam logic        LAST_STOP   = (STOP_BITS == 2);
   localparam logic        ODD_PAR     = (PARITY == PAR_ODD);

   // ---------------- transmit path ----------------
   txState_e             txState_q;
   logic [15:0]          txCnt_q;
   logic [2:0]           txIdx_q;
   logic                 txStopIdx_q;
   logic [DATA_BITS-1:0] txShift_q;
   logic                 txPar_q;
   logic                 tx_q;
   logic                 txLast_q;
   logic [DATA_BITS-1:0] txHead;
   logic                 txFull;
   logic                 txEmpty;
   logic                 txPop;
   logic                 txBit;
   logic                 txCntZero;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_valid && tx_ready),
      .wdata_i (tx_data),
      .pop_i   (txPop),
      .rdata_o (txHead),
      .full_o  (txFull),
      .empty_o (txEmpty)
   );

   assign txCntZero = (txCnt_q == '0);
   // Popping at the end of the last stop bit lets frames run back to back.
   assign txPop = !txEmpty &&
                  ((txState_q == TX_IDLE) ||
                   ((txState_q == TX_STOP) && txCntZero && (txStopIdx_q == LAST_STOP)));

   always_comb begin
      txBit = 1'b1;
      case (txState_q)
         TX_START: txBit = 1'b0;
         TX_DATA:  txBit = txShift_q[0];
         TX_PAR:   txBit = txPar_q;
         default:  txBit = 1'b1;
      endcase
   end

   // The line is a registered copy of the state's bit, which adds one cycle of latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txState_q   <= TX_IDLE;
         txCnt_q     <= '0;
         txIdx_q     <= '0;
         txStopIdx_q <= 1'b0;
         txShift_q   <= '0;
         txPar_q     <= 1'b0;
         tx_q        <= 1'b1;
         txLast_q    <= 1'b0;
      end else begin
         tx_q     <= txBit;
         txLast_q <= (txState_q != TX_IDLE);
         if (txPop) begin
            txShift_q <= txHead;
            txPar_q   <= (^txHead) ^ ODD_PAR;
            txState_q <= TX_START;
            txCnt_q   <= BIT_RELOAD;
         end else if (txState_q != TX_IDLE) begin
            if (!txCntZero) begin
               txCnt_q <= txCnt_q - 16'd1;
            end else begin
               txCnt_q <= BIT_RELOAD;
               case (txState_q)
                  TX_START: begin
                     txState_q <= TX_DATA;
                     txIdx_q   <= '0;
                  end
                  TX_DATA: begin
                     txShift_q <= txShift_q >> 1;
                     if (txIdx_q == LAST_BIT) begin
                        txState_q   <= (PARITY == PAR_NONE) ? TX_STOP : TX_PAR;
                        txStopIdx_q <= 1'b0;
                     end else begin
                        txIdx_q <= txIdx_q + 3'd1;
                     end
                  end
                  TX_PAR: begin
                     txState_q   <= TX_STOP;
                     txStopIdx_q <= 1'b0;
                  end
                  TX_STOP: begin
                     if (txStopIdx_q == LAST_STOP) txState_q <= TX_IDLE;
                     else                          txStopIdx_q <= 1'b1;
                  end
                  default: txState_q <= TX_IDLE;
               endcase
            end
         end
      end
   end

   assign tx       = tx_q;
   assign tx_ready = !txFull;
   assign tx_busy  = !txEmpty || (txState_q != TX_IDLE) || txLast_q;

   // ---------------- receive path ----------------
   rxState_e             rxState_q;
   logic                 rxMeta_q;
   logic                 rxSync_q;
   logic [15:0]          rxCnt_q;
   logic [2:0]           rxIdx_q;
   logic [DATA_BITS-1:0] rxShift_q;
   logic                 rxPerr_q;
   logic                 rxOvr_q;
   logic [DATA_BITS+1:0] rxHead;
   logic                 rxFull;
   logic                 rxEmpty;
   logic                 rxPush;
   logic                 rxOvrSet;
   logic                 rxCntZero;

   uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rxPush),
      .wdata_i ({rxShift_q, rxPerr_q, !rxSync_q}),
      .pop_i   (rx_ready),
      .rdata_o (rxHead),
      .full_o  (rxFull),
      .empty_o (rxEmpty)
   );

   assign rxCntZero = (rxCnt_q == '0);
   assign rxPush    = (rxState_q == RX_STOP) && rxCntZero;
   assign rxOvrSet  = rxPush && rxFull && !rx_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
      end else begin
         rxMeta_q <= rx;
         rxSync_q <= rxMeta_q;
      end
   end

   // START waits half a bit so every later sample lands at bit centre.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxState_q <= RX_IDLE;
         rxCnt_q   <= '0;
         rxIdx_q   <= '0;
         rxShift_q <= '0;
         rxPerr_q  <= 1'b0;
      end else begin
         case (rxState_q)
            RX_IDLE: begin
               if (!rxSync_q) begin
                  rxState_q <= RX_START;
                  rxCnt_q   <= HALF_RELOAD;
                  rxPerr_q  <= 1'b0;
               end
            end
            RX_BREAK: begin
               if (rxSync_q) rxState_q <= RX_IDLE;
            end
            default: begin
               if (!rxCntZero) begin
                  rxCnt_q <= rxCnt_q - 16'd1;
               end else begin
                  rxCnt_q <= BIT_RELOAD;
                  case (rxState_q)
                     RX_START: begin
                        rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
                        rxIdx_q   <= '0;
                     end
                     RX_DATA: begin
                        rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
                        if (rxIdx_q == LAST_BIT)
                           rxState_q <= (PARITY == PAR_NONE) ? RX_STOP : RX_PAR;
                        else
                           rxIdx_q <= rxIdx_q + 3'd1;
                     end
                     RX_PAR: begin
                        rxPerr_q  <= rxSync_q ^ (^rxShift_q) ^ ODD_PAR;
                        rxState_q <= RX_STOP;
                     end
                     RX_STOP:  rxState_q <= rxSync_q ? RX_IDLE : RX_BREAK;
                     default:  rxState_q <= RX_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            rxOvr_q <= 1'b0;
      else if (rxOvrSet)   rxOvr_q <= 1'b1;
      else if (rx_ovr_clr) rxOvr_q <= 1'b0;
   end

   assign rx_data  = rxHead[DATA_BITS+1:2];
   assign rx_perr  = rxHead[1];
   assign rx_ferr  = rxHead[0];
   assign rx_valid = !rxEmpty;
   assign rx_ovr   = rxOvr_q;

endmodule

// File: tb/tb_uart_ctl_cfg.sv
// Directed bench: dutA is 8N1 in loopback, dutB is 8E2 with its rx line
// driven by the bench.
module tb_uart_ctl_cfg;

   localparam int DIV = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rstA, txA, txValidA, txReadyA, txBusyA, rxPerrA, rxFerrA, rxValidA, rxReadyA, rxOvrA, rxOvrClrA;
   logic [7:0] txDataA, rxDataA;
   logic       rstB, rxB, txB, txValidB, txReadyB, txBusyB, rxPerrB, rxFerrB, rxValidB, rxReadyB, rxOvrB, rxOvrClrB;
   logic [7:0] txDataB, rxDataB;

   uart_ctl_cfg #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dutA (
      .clk(clk), .rst(rstA), .rx(txA), .tx(txA),
      .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReadyA), .tx_busy(txBusyA),
      .rx_data(rxDataA), .rx_perr(rxPerrA), .rx_ferr(rxFerrA), .rx_valid(rxValidA),
      .rx_ready(rxReadyA), .rx_ovr(rxOvrA), .rx_ovr_clr(rxOvrClrA)
   );

   uart_ctl_cfg #(.DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dutB (
      .clk(clk), .rst(rstB), .rx(rxB), .tx(txB),
      .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReadyB), .tx_busy(txBusyB),
      .rx_data(rxDataB), .rx_perr(rxPerrB), .rx_ferr(rxFerrB), .rx_valid(rxValidB),
      .rx_ready(rxReadyB), .rx_ovr(rxOvrB), .rx_ovr_clr(rxOvrClrB)
   );

   int nCompared = 0;
   int nMismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyTx(input bit toB, input logic [7:0] d);
      if (toB) begin txDataB = d; txValidB = 1'b1; end
      else     begin txDataA = d; txValidA = 1'b1; end
      @(negedge clk);
      txValidA = 1'b0;
      txValidB = 1'b0;
   endtask

   // Drives the first n bits of a frame onto dutB's rx line, LSB first.
   task automatic applyStimulus(input logic [15:0] bits, input int n);
      for (int k = 0; k < n; k++) begin
         rxB = bits[k];
         repeat (DIV) @(negedge clk);
      end
   endtask

   task automatic popRx(input bit toB);
      if (toB) rxReadyB = 1'b1; else rxReadyA = 1'b1;
      @(negedge clk);
      rxReadyA = 1'b0;
      rxReadyB = 1'b0;
   endtask

   function automatic logic [15:0] frameB(input logic [7:0] d, input logic p, input logic s);
      return {4'b0000, s, s, p, d, 1'b0};
   endfunction

   int         n;
   int         t0;
   logic [11:0] bitv;
   logic        busyPre;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstA = 1'b0; rstB = 1'b0; rxB = 1'b1;
      txDataA = '0; txValidA = 1'b0; rxReadyA = 1'b0; rxOvrClrA = 1'b0;
      txDataB = '0; txValidB = 1'b0; rxReadyB = 1'b0; rxOvrClrB = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("resetA", {txA, txReadyA, txBusyA, rxValidA, rxPerrA, rxFerrA, rxOvrA, rxDataA},
                  {1'b1, 1'b1, 5'b00000, 8'h00});
      checkOutput("resetB", {txB, txReadyB, txBusyB, rxValidB, rxPerrB, rxFerrB, rxOvrB, rxDataB},
                  {1'b1, 1'b1, 5'b00000, 8'h00});
      rstA = 1'b1; rstB = 1'b1;
      repeat (2) @(negedge clk);

      // Single 8N1 word through loopback.
      applyTx(1'b0, 8'hA5);
      t0 = cyc;
      n = 0;
      while (txA && n < 20) begin @(negedge clk); n++; end
      checkOutput("txLatencyA", n, 2);
      while (txBusyA && (cyc - t0) < 1000) @(negedge clk);
      checkOutput("frameLenA", cyc - t0, 2 + 10 * DIV);
      n = 0;
      while (!rxValidA && n < 400) begin @(negedge clk); n++; end
      checkOutput("rxValidA", rxValidA, 1);
      checkOutput("rxDataA", rxDataA, 8'hA5);
      checkOutput("rxErrA", {rxPerrA, rxFerrA}, 2'b00);
      popRx(1'b0);
      checkOutput("rxEmptyA", rxValidA, 0);

      // Fill TX FIFO while busy; 17 back-to-back frames overrun the RX FIFO.
      applyTx(1'b0, 8'h10);
      t0 = cyc;
      for (int i = 1; i <= 16; i++) applyTx(1'b0, 8'(8'h10 + i));
      checkOutput("txReadyFull", txReadyA, 0);
      checkOutput("txBusyBurst", txBusyA, 1);
      while (txBusyA && (cyc - t0) < 4000) @(negedge clk);
      checkOutput("burstLen", cyc - t0, 2 + 17 * 10 * DIV);
      repeat (4) @(negedge clk);
      checkOutput("rxOvrSet", rxOvrA, 1);
      for (int i = 0; i < 16; i++) begin
         checkOutput("rxBurstWord", rxDataA, 8'(8'h10 + i));
         popRx(1'b0);
      end
      checkOutput("rxDrained", rxValidA, 0);
      checkOutput("rxOvrSticky", rxOvrA, 1);
      rxOvrClrA = 1'b1;
      @(negedge clk);
      rxOvrClrA = 1'b0;
      checkOutput("rxOvrClr", rxOvrA, 0);

      // 8E2 transmit: 0x07 has three ones, so even parity bit is 1.
      applyTx(1'b1, 8'h07);
      n = 0;
      while (txB && n < 20) begin @(negedge clk); n++; end
      checkOutput("txLatencyB", n, 2);
      busyPre = 1'b0;
      for (int k = 0; k < 12; k++) begin
         repeat (8) @(negedge clk);
         bitv[k] = txB;
         repeat (7) @(negedge clk);
         if (k == 11) busyPre = txBusyB;
         @(negedge clk);
      end
      checkOutput("txFrameB", bitv, 12'hE0E);
      checkOutput("txParB", bitv[9], 1);
      checkOutput("txBusyLastStop", busyPre, 1);
      checkOutput("txBusyDone", txBusyB, 0);

      // Receive with correct and with flipped parity.
      applyStimulus(frameB(8'h07, 1'b1, 1'b1), 12);
      checkOutput("rxGoodB", {rxValidB, rxPerrB, rxFerrB, rxDataB}, {3'b100, 8'h07});
      popRx(1'b1);
      applyStimulus(frameB(8'h3C, 1'b1, 1'b1), 12);
      checkOutput("rxPerrB", {rxValidB, rxPerrB, rxFerrB, rxDataB}, {3'b110, 8'h3C});
      popRx(1'b1);
      checkOutput("rxEmptyB", rxValidB, 0);

      // Framing error followed by a held-low break.
      applyStimulus(frameB(8'h5A, 1'b0, 1'b0), 11);
      rxB = 1'b0;
      repeat (5 * DIV) @(negedge clk);
      rxB = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      checkOutput("rxFerrB", {rxValidB, rxPerrB, rxFerrB, rxDataB}, {3'b101, 8'h5A});
      popRx(1'b1);
      checkOutput("rxBreakOneWord", rxValidB, 0);

      // Reset in the middle of a TX data bit and an RX frame.
      applyTx(1'b1, 8'hC3);
      applyStimulus(frameB(8'h81, 1'b0, 1'b1), 4);
      repeat (8) @(negedge clk);
      checkOutput("txPreReset", txB, 0);
      #2;
      rstB = 1'b0;
      rxB = 1'b1;
      #1;
      checkOutput("txAtReset", {txB, txBusyB, rxValidB}, 3'b100);
      @(negedge clk);
      rstB = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      checkOutput("idleAfterReset", {txB, txBusyB, rxValidB}, 3'b100);
      applyStimulus(frameB(8'h96, 1'b0, 1'b1), 12);
      checkOutput("rxAfterReset", {rxValidB, rxPerrB, rxFerrB, rxDataB}, {3'b100, 8'h96});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
